packet_channel_arbiter: RTL and testbench
=========================================

// Module: packet_channel_arbiter
// PURPOSE
//  Shares one FX2/USB read port among NUM_CHAN packet_builder instances.
//  Round-robin selects a channel with a packet ready and raises have_pkt_rdy to the FX2.
//  Gates the FX2 read enable to the selected builder only and muxes that builder's data out.
//  Drops the builder's rden after packet_complete, so each rden burst carries exactly one packet.
// PARAMETERS
//  NUM_CHAN  4  number of packet_builder channels (2..16)
//  CHAN_W    2  width of channel index, = clog2(NUM_CHAN)
// PORTS
//  clk           in   1            system clock, all logic on rising edge
//  reset_n       in   1            asynchronous active-low reset
//  usb_rden      in   1            FX2 read enable; high for one packet read burst
//  chan_ready    in   NUM_CHAN     per-channel: full packet (header+payload) waiting
//  pb_complete   in   NUM_CHAN     per-channel packet_builder packet_complete
//  pb_data       in   16*NUM_CHAN  per-channel packet_data, chan i at [16i+15:16i]
//  pb_rden       out  NUM_CHAN     one-hot rden to packet_builders
//  packet_data   out  16           muxed output data to FX2
//  have_pkt_rdy  out  1            packet armed, FX2 may start reading
//  cur_chan      out  CHAN_W       channel currently armed/sending
//  abort_pulse   out  1            1-cycle pulse: usb_rden fell before pb_complete
//  pkt_count     out  16           completed packets, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; pb_rden=0; have_pkt_rdy=0; cur_chan=0;
//    abort_pulse=0; pkt_count=0; rr pointer last=NUM_CHAN-1, so channel 0 has priority first.
//  States: IDLE, ARMED, SEND, DRAIN.
//  IDLE: if |chan_ready, register cur_chan = first i set, searching last+1, last+2, .. mod NUM_CHAN.
//    Go to ARMED next cycle. Otherwise stay in IDLE.
//    Selection is evaluated only in IDLE; chan_ready changes in other states are ignored.
//  ARMED: have_pkt_rdy=1 (registered). Leave when usb_rden=1, go to SEND.
//    A chan_ready[cur_chan] drop here is ignored; the channel stays committed.
//  pb_rden[cur_chan] = usb_rden & (state==ARMED|SEND), combinational.
//    The builder sees rden on the same edge the FX2 starts, so header word 0 is already valid.
//    All other pb_rden bits are 0 at all times.
//  SEND: have_pkt_rdy=1.
//    pb_complete[cur_chan]=1 -> DRAIN; last<=cur_chan; pkt_count+1; have_pkt_rdy=0 next cycle.
//    usb_rden=0 with pb_complete=0 (abort) -> IDLE; abort_pulse=1 for one cycle;
//      last<=cur_chan; pkt_count unchanged.
//    pb_complete and usb_rden fall on the same cycle -> treat as complete, not abort.
//  DRAIN: pb_rden=0 (builder reset requirement), have_pkt_rdy=0.
//    Wait for usb_rden=0, then go to IDLE. Minimum one cycle in DRAIN even if usb_rden is already 0.
//  packet_data = pb_data[cur_chan], combinational, valid in every state.
//  Packet-to-packet minimum: complete -> DRAIN(>=1) -> IDLE(1) -> ARMED.
//    have_pkt_rdy is low for at least 2 cycles between packets.
//  No starvation: a continuously ready channel is served within NUM_CHAN packets.
//  cur_chan is stable from ARMED entry until IDLE re-entry.
// TESTING
//  1 Reset mid-SEND: reset_n low for 1 cycle
//    -> all outputs 0 immediately (async); next grant goes to channel 0.
//  2 chan_ready=4'b1111, FX2 reads 256 words per packet; 8 packets
//    -> cur_chan sequence 0,1,2,3,0,1,2,3; pkt_count=8.
//  3 chan_ready=4'b0100 only
//    -> cur_chan=2; pb_rden==4'b0100 exactly while usb_rden=1; packet_data==pb_data[47:32].
//  4 usb_rden falls at word 100 before pb_complete
//    -> abort_pulse 1 cycle; pkt_count unchanged; next grant is channel 3 when all are ready.
//  5 pb_complete rises while usb_rden stays high 3 more cycles
//    -> pb_rden=0 and have_pkt_rdy=0 within 1 cycle; IDLE only after usb_rden=0.
//  6 pkt_count preloaded near wrap by 65536 completions -> pkt_count wraps 16'hFFFF -> 16'h0000.

Source files
------------

// File: rtl/packet_channel_arbiter.sv
// ---------------------------------------------------------------------------
// packet_channel_arbiter
//   Shares one FX2/USB read port among NUM_CHAN packet_builder channels.
//   A round-robin pick among ready channels is armed toward the FX2. The FX2
//   read enable is gated to that builder only, and its data is muxed out.
//   The builder's rden drops after packet_complete, so every rden burst
//   carries exactly one packet.
//
// Parameters
//   NUM_CHAN        number of packet_builder channels (2..16)
//   CHAN_W          channel index width, clog2(NUM_CHAN)
//   PKT_COUNT_INIT  reset value of pkt_count (normally 0)
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   usb_rden      FX2 read enable, high for one packet read burst
//   chan_ready    per-channel full packet waiting
//   pb_complete   per-channel packet_builder packet_complete
//   pb_data       per-channel packet data, chan i at [16i+15:16i]
//   pb_rden       one-hot read enable to the packet_builders
//   packet_data   muxed data to the FX2
//   have_pkt_rdy  packet armed, FX2 may start reading
//   cur_chan      channel currently armed/sending
//   abort_pulse   1-cycle pulse: usb_rden fell before pb_complete
//   pkt_count     completed packets, wrapping
// ---------------------------------------------------------------------------
module packet_channel_arbiter #(
   parameter int unsigned NUM_CHAN       = 4,
   parameter int unsigned CHAN_W         = 2,
   parameter logic [15:0] PKT_COUNT_INIT = 16'h0000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     usb_rden,
   input  logic [NUM_CHAN-1:0]      chan_ready,
   input  logic [NUM_CHAN-1:0]      pb_complete,
   input  logic [16*NUM_CHAN-1:0]   pb_data,
   output logic [NUM_CHAN-1:0]      pb_rden,
   output logic [15:0]              packet_data,
   output logic                     have_pkt_rdy,
   output logic [CHAN_W-1:0]        cur_chan,
   output logic                     abort_pulse,
   output logic [15:0]              pkt_count
);

   typedef enum logic [1:0] {IDLE, ARMED, SEND, DRAIN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CHAN_W-1:0] last;
   logic [CHAN_W-1:0] pick;
   logic [CHAN_W-1:0] idx;
   logic              found;
   logic              cur_complete;
   logic              rden_gate;

   // Round-robin search: first ready channel starting just after 'last'.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_CHAN; k++) begin
         idx = CHAN_W'((32'(last) + k) % NUM_CHAN);
         if (!found && chan_ready[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Completion flag of the committed channel.
   always_comb begin
      cur_complete = 1'b0;
      for (int unsigned i = 0; i < NUM_CHAN; i++) begin
         if (cur_chan == CHAN_W'(i)) cur_complete = pb_complete[i];
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = ARMED;
         ARMED:   if (usb_rden) state_nxt = SEND;
         // Completion wins over a simultaneous usb_rden fall.
         SEND:    if (cur_complete)  state_nxt = DRAIN;
                  else if (!usb_rden) state_nxt = IDLE;
         DRAIN:   if (!usb_rden) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: decoded from the state register, rden/data gated by cur_chan.
   always_comb begin
      have_pkt_rdy = (state == ARMED) || (state == SEND);
      rden_gate    = usb_rden && ((state == ARMED) || (state == SEND));
      pb_rden      = '0;
      packet_data  = '0;
      for (int unsigned i = 0; i < NUM_CHAN; i++) begin
         if (cur_chan == CHAN_W'(i)) begin
            pb_rden[i]  = rden_gate;
            packet_data = pb_data[16*i +: 16];
         end
      end
   end

   // Channel commitment, round-robin history, abort pulse and packet counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_chan    <= '0;
         last        <= CHAN_W'(NUM_CHAN - 1);
         abort_pulse <= 1'b0;
         pkt_count   <= PKT_COUNT_INIT;
      end else begin
         abort_pulse <= 1'b0;
         case (state)
            IDLE: if (found) cur_chan <= pick;
            SEND: begin
               if (cur_complete) begin
                  last      <= cur_chan;
                  pkt_count <= pkt_count + 16'd1;
               end else if (!usb_rden) begin
                  last        <= cur_chan;
                  abort_pulse <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_channel_arbiter.sv
module tb_packet_channel_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        usb_rden;
   logic [3:0]  chan_ready;
   logic [3:0]  pb_complete;
   logic [63:0] pb_data;

   logic [3:0]  pb_rden;
   logic [15:0] packet_data;
   logic        have_pkt_rdy;
   logic [1:0]  cur_chan;
   logic        abort_pulse;
   logic [15:0] pkt_count;

   logic [3:0]  w_pb_rden;
   logic [15:0] w_packet_data;
   logic        w_have_pkt_rdy;
   logic [1:0]  w_cur_chan;
   logic        w_abort_pulse;
   logic [15:0] w_pkt_count;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   packet_channel_arbiter #(.NUM_CHAN(4), .CHAN_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .usb_rden(usb_rden), .chan_ready(chan_ready),
      .pb_complete(pb_complete), .pb_data(pb_data), .pb_rden(pb_rden),
      .packet_data(packet_data), .have_pkt_rdy(have_pkt_rdy), .cur_chan(cur_chan),
      .abort_pulse(abort_pulse), .pkt_count(pkt_count)
   );

   // Second instance with the counter starting two packets before wrap.
   packet_channel_arbiter #(.NUM_CHAN(4), .CHAN_W(2), .PKT_COUNT_INIT(16'hFFFE)) u_wrap (
      .clk(clk), .reset_n(reset_n), .usb_rden(usb_rden), .chan_ready(chan_ready),
      .pb_complete(pb_complete), .pb_data(pb_data), .pb_rden(w_pb_rden),
      .packet_data(w_packet_data), .have_pkt_rdy(w_have_pkt_rdy), .cur_chan(w_cur_chan),
      .abort_pulse(w_abort_pulse), .pkt_count(w_pkt_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_armed(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (have_pkt_rdy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // FX2 reads n words; the builder flags complete on the last one.
   task automatic read_words(input int n, input int ch);
      usb_rden = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) pb_complete = 4'b0001 << ch;
         tick();
      end
      usb_rden    = 1'b0;
      pb_complete = 4'b0000;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; usb_rden = 1'b0; chan_ready = 4'b0000; pb_complete = 4'b0000;
      pb_data = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
      tick(); tick();
      ncmp++; if (pb_rden !== 4'b0000) begin nerr++; $display("FAIL reset_pb_rden: got %b expected 0000", pb_rden); end
      ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL reset_have_pkt_rdy: got %b expected 0", have_pkt_rdy); end
      ncmp++; if (cur_chan !== 2'd0) begin nerr++; $display("FAIL reset_cur_chan: got %0d expected 0", cur_chan); end
      ncmp++; if (abort_pulse !== 1'b0) begin nerr++; $display("FAIL reset_abort: got %b expected 0", abort_pulse); end
      ncmp++; if (pkt_count !== 16'd0) begin nerr++; $display("FAIL reset_pkt_count: got %h expected 0000", pkt_count); end
      ncmp++; if (w_pkt_count !== 16'hFFFE) begin nerr++; $display("FAIL reset_wrap_count: got %h expected fffe", w_pkt_count); end
      reset_n = 1'b1;
      tick();
      ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL idle_no_ready: got %b expected 0", have_pkt_rdy); end
   endtask

   task automatic test_round_robin();
      bit ok;
      chan_ready = 4'b1111;
      for (int p = 0; p < 8; p++) begin
         wait_armed(ok);
         ncmp++; if (!ok) begin nerr++; $display("FAIL rr_arm_timeout: packet %0d got no have_pkt_rdy expected 1", p); end
         ncmp++; if (cur_chan !== 2'(p % 4)) begin nerr++; $display("FAIL rr_cur_chan: packet %0d got %0d expected %0d", p, cur_chan, p % 4); end
         read_words(256, p % 4);
         ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL rr_drain_rdy: packet %0d got %b expected 0", p, have_pkt_rdy); end
      end
      ncmp++; if (pkt_count !== 16'd8) begin nerr++; $display("FAIL rr_pkt_count: got %0d expected 8", pkt_count); end
   endtask

   task automatic test_reset_mid_send();
      bit ok;
      chan_ready = 4'b0010;
      tick(); tick();
      wait_armed(ok);
      ncmp++; if (cur_chan !== 2'd1) begin nerr++; $display("FAIL rms_pre_chan: got %0d expected 1", cur_chan); end
      read_words(4, 1);
      chan_ready = 4'b1111;
      wait_armed(ok);
      ncmp++; if (cur_chan !== 2'd2) begin nerr++; $display("FAIL rms_second_chan: got %0d expected 2", cur_chan); end
      usb_rden = 1'b1;
      tick(); tick();
      reset_n = 1'b0;
      #1;
      ncmp++; if (pb_rden !== 4'b0000) begin nerr++; $display("FAIL rms_pb_rden: got %b expected 0000", pb_rden); end
      ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL rms_have_pkt_rdy: got %b expected 0", have_pkt_rdy); end
      ncmp++; if (cur_chan !== 2'd0) begin nerr++; $display("FAIL rms_cur_chan: got %0d expected 0", cur_chan); end
      ncmp++; if (pkt_count !== 16'd0) begin nerr++; $display("FAIL rms_pkt_count: got %0d expected 0", pkt_count); end
      ncmp++; if (abort_pulse !== 1'b0) begin nerr++; $display("FAIL rms_abort: got %b expected 0", abort_pulse); end
      usb_rden = 1'b0;
      tick();
      reset_n = 1'b1;
      wait_armed(ok);
      ncmp++; if (!ok || cur_chan !== 2'd0) begin nerr++; $display("FAIL rms_regrant: got ok=%b chan %0d expected ok=1 chan 0", ok, cur_chan); end
   endtask

   task automatic test_pkt_wrap();
      bit ok;
      ncmp++; if (w_pkt_count !== 16'hFFFE) begin nerr++; $display("FAIL wrap_start: got %h expected fffe", w_pkt_count); end
      read_words(8, 0);
      ncmp++; if (w_pkt_count !== 16'hFFFF) begin nerr++; $display("FAIL wrap_ffff: got %h expected ffff", w_pkt_count); end
      wait_armed(ok);
      ncmp++; if (cur_chan !== 2'd1) begin nerr++; $display("FAIL wrap_chan: got %0d expected 1", cur_chan); end
      read_words(8, 1);
      ncmp++; if (w_pkt_count !== 16'h0000) begin nerr++; $display("FAIL wrap_zero: got %h expected 0000", w_pkt_count); end
      ncmp++; if (pkt_count !== 16'd2) begin nerr++; $display("FAIL wrap_main_count: got %0d expected 2", pkt_count); end
   endtask

   task automatic test_abort();
      bit ok;
      chan_ready = 4'b0100;
      wait_armed(ok);
      ncmp++; if (cur_chan !== 2'd2) begin nerr++; $display("FAIL abort_chan: got %0d expected 2", cur_chan); end
      usb_rden = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      ncmp++; if (abort_pulse !== 1'b0) begin nerr++; $display("FAIL abort_early: got %b expected 0", abort_pulse); end
      usb_rden   = 1'b0;
      chan_ready = 4'b1111;
      tick();
      ncmp++; if (abort_pulse !== 1'b1) begin nerr++; $display("FAIL abort_pulse: got %b expected 1", abort_pulse); end
      ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL abort_rdy: got %b expected 0", have_pkt_rdy); end
      ncmp++; if (pkt_count !== 16'd2) begin nerr++; $display("FAIL abort_count: got %0d expected 2", pkt_count); end
      tick();
      ncmp++; if (abort_pulse !== 1'b0) begin nerr++; $display("FAIL abort_width: got %b expected 0", abort_pulse); end
      ncmp++; if (cur_chan !== 2'd3 || have_pkt_rdy !== 1'b1) begin nerr++; $display("FAIL abort_next_grant: got chan %0d rdy %b expected chan 3 rdy 1", cur_chan, have_pkt_rdy); end
   endtask

   task automatic test_complete_hold();
      usb_rden = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      pb_complete = 4'b1000;
      tick();
      pb_complete = 4'b0000;
      ncmp++; if (pb_rden !== 4'b0000) begin nerr++; $display("FAIL hold_pb_rden: got %b expected 0000", pb_rden); end
      ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL hold_rdy: got %b expected 0", have_pkt_rdy); end
      ncmp++; if (pkt_count !== 16'd3) begin nerr++; $display("FAIL hold_count: got %0d expected 3", pkt_count); end
      for (int i = 0; i < 3; i++) begin
         tick();
         ncmp++; if (have_pkt_rdy !== 1'b0 || pb_rden !== 4'b0000) begin nerr++; $display("FAIL hold_drain_%0d: got rdy %b rden %b expected 0 0000", i, have_pkt_rdy, pb_rden); end
      end
      usb_rden = 1'b0;
      tick();
      ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL hold_idle: got %b expected 0", have_pkt_rdy); end
      tick();
      ncmp++; if (have_pkt_rdy !== 1'b1 || cur_chan !== 2'd0) begin nerr++; $display("FAIL hold_rearm: got rdy %b chan %0d expected 1 chan 0", have_pkt_rdy, cur_chan); end
      read_words(4, 0);
   endtask

   task automatic test_single_chan();
      bit ok;
      chan_ready = 4'b0100;
      wait_armed(ok);
      ncmp++; if (cur_chan !== 2'd2) begin nerr++; $display("FAIL single_chan: got %0d expected 2", cur_chan); end
      ncmp++; if (pb_rden !== 4'b0000) begin nerr++; $display("FAIL single_armed_rden: got %b expected 0000", pb_rden); end
      ncmp++; if (packet_data !== 16'hC2C2) begin nerr++; $display("FAIL single_data_armed: got %h expected c2c2", packet_data); end
      usb_rden = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         ncmp++; if (pb_rden !== 4'b0100) begin nerr++; $display("FAIL single_rden_%0d: got %b expected 0100", i, pb_rden); end
         tick();
      end
      pb_data[47:32] = 16'h1234;
      #1;
      ncmp++; if (packet_data !== 16'h1234) begin nerr++; $display("FAIL single_data_mux: got %h expected 1234", packet_data); end
      pb_complete = 4'b0100;
      tick();
      usb_rden = 1'b0; pb_complete = 4'b0000; pb_data[47:32] = 16'hC2C2;
      #1;
      ncmp++; if (pb_rden !== 4'b0000) begin nerr++; $display("FAIL single_drain_rden: got %b expected 0000", pb_rden); end
      ncmp++; if (pkt_count !== 16'd5) begin nerr++; $display("FAIL single_count: got %0d expected 5", pkt_count); end
   endtask

   task automatic test_same_cycle_fall();
      bit ok;
      chan_ready = 4'b1000;
      wait_armed(ok);
      ncmp++; if (cur_chan !== 2'd3) begin nerr++; $display("FAIL fall_chan: got %0d expected 3", cur_chan); end
      usb_rden = 1'b1;
      tick(); tick();
      usb_rden = 1'b0; pb_complete = 4'b1000;
      tick();
      pb_complete = 4'b0000;
      ncmp++; if (abort_pulse !== 1'b0) begin nerr++; $display("FAIL fall_abort: got %b expected 0", abort_pulse); end
      ncmp++; if (pkt_count !== 16'd6) begin nerr++; $display("FAIL fall_count: got %0d expected 6", pkt_count); end
      ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL fall_rdy: got %b expected 0", have_pkt_rdy); end
      chan_ready = 4'b0000;
      tick(); tick();
      ncmp++; if (have_pkt_rdy !== 1'b0) begin nerr++; $display("FAIL fall_idle: got %b expected 0", have_pkt_rdy); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_reset_mid_send();
      test_pkt_wrap();
      test_abort();
      test_complete_hold();
      test_single_chan();
      test_same_cycle_fall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
